// File: rtl/ad7763_pkg.sv
// Shared constants and helpers for the AD7763 capture/decimation path.
package ad7763_pkg;

    localparam int unsigned ADC_DATA_WIDTH  = 24;
    localparam int unsigned MAX_DEC_LOG2    = 8;
    localparam int unsigned ACC_WIDTH       = ADC_DATA_WIDTH + MAX_DEC_LOG2;
    localparam int unsigned LOG2_IN_WIDTH   = 4;
    localparam int unsigned BLOCK_CNT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } dec_state_e;

    // Limit a requested decimation exponent to the supported maximum.
    function automatic logic [LOG2_IN_WIDTH-1:0] clamp_log2(
        input logic [LOG2_IN_WIDTH-1:0] k,
        input int unsigned              max_log2
    );
        if (32'(k) > max_log2) begin
            return LOG2_IN_WIDTH'(max_log2);
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_ad7763_decimator_if.sv
// Single AXI-Stream channel carrying one signed sample per beat.
interface axis_ad7763_decimator_if
    import ad7763_pkg::*;
#(
    parameter int unsigned DW = ADC_DATA_WIDTH
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_ad7763_decimator_out_reg.sv
// Single-entry AXIS output register: holds data/valid until the sink accepts.
module axis_out_reg #(
    parameter int unsigned DW = 24
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [DW-1:0] r_data;
    logic          r_valid;

    // A load always wins, so a drain and a new result in one cycle stay back-to-back.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/axis_ad7763_decimator.sv
// Boxcar accumulate-and-dump decimator over 2^k AXIS samples with rounded output.
module axis_ad7763_decimator
    import ad7763_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int unsigned MAX_LOG2   = MAX_DEC_LOG2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic [LOG2_IN_WIDTH-1:0]   dec_log2,
    axis_ad7763_decimator_if.slave     s_axis,
    axis_ad7763_decimator_if.master    m_axis,
    output logic [BLOCK_CNT_WIDTH-1:0] block_count
);

    // Accumulator width follows any override of the sample width or max exponent.
    localparam int unsigned AW = ACC_WIDTH + (DATA_WIDTH - ADC_DATA_WIDTH) + (MAX_LOG2 - MAX_DEC_LOG2);
    localparam int unsigned CW = MAX_LOG2 + 1;
    localparam int unsigned KW = LOG2_IN_WIDTH;

    dec_state_e                 r_state;
    logic signed [AW-1:0]       r_acc;
    logic [CW-1:0]              r_cnt;
    logic [KW-1:0]              r_k_lat;
    logic                       r_rdy_en;
    logic [BLOCK_CNT_WIDTH-1:0] r_block_count;

    logic [KW-1:0]              w_k_in;
    logic [KW-1:0]              w_k;
    logic                       w_last;
    logic                       w_out_busy;
    logic                       w_xfer;
    logic                       w_done;
    logic signed [AW-1:0]       w_sample_ext;
    logic signed [AW-1:0]       w_sum;
    logic signed [AW-1:0]       w_round;
    logic signed [AW-1:0]       w_rounded;
    logic [DATA_WIDTH-1:0]      w_out_data;
    logic                       w_out_valid;

    // Exponent in force: live (clamped) input in IDLE, latched value mid-block.
    assign w_k_in = clamp_log2(dec_log2, MAX_LOG2);
    assign w_k    = (r_state == ST_IDLE) ? w_k_in : r_k_lat;

    // Next accepted sample closes the block.
    assign w_last = (r_state == ST_IDLE) ? (w_k_in == '0)
                                         : (CW'(r_cnt + CW'(1)) == (CW'(1) << r_k_lat));

    // Stall only when a completion would collide with a result the sink has not taken.
    assign w_out_busy    = w_out_valid && !m_axis.tready;
    assign s_axis.tready = r_rdy_en && !(enable && w_out_busy && w_last);
    assign w_xfer        = s_axis.tvalid && s_axis.tready;
    assign w_done        = enable && w_xfer && w_last;

    // Running sum including the current sample, then round-half-up and scale.
    assign w_sample_ext = {{MAX_LOG2{s_axis.tdata[DATA_WIDTH-1]}}, s_axis.tdata};
    assign w_sum        = ((r_state == ST_IDLE) ? AW'(0) : r_acc) + w_sample_ext;
    assign w_round      = (w_k == '0) ? AW'(0) : (AW'(1) << (w_k - KW'(1)));
    assign w_rounded    = (w_sum + w_round) >>> w_k;

    // Accumulator FSM, block counter and the ready-after-reset flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_k_lat       <= '0;
            r_rdy_en      <= 1'b0;
            r_block_count <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_done) begin
                r_block_count <= r_block_count + BLOCK_CNT_WIDTH'(1);
            end
            if (!enable) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_state <= ST_ACCUM;
                    r_acc   <= w_sum;
                    if (r_state == ST_IDLE) begin
                        r_k_lat <= w_k_in;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

    axis_out_reg #(
        .DW (DATA_WIDTH)
    ) u_out_reg (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_load  (w_done),
        .i_data  (w_rounded[DATA_WIDTH-1:0]),
        .i_ready (m_axis.tready),
        .o_data  (w_out_data),
        .o_valid (w_out_valid)
    );

    assign m_axis.tdata  = w_out_data;
    assign m_axis.tvalid = w_out_valid;
    assign block_count   = r_block_count;

endmodule

// File: tb/tb_axis_ad7763_decimator.sv
// Self-checking bench for the AXIS boxcar decimator.
module tb_axis_ad7763_decimator;
    import ad7763_pkg::*;

    logic        aclk     = 1'b0;
    logic        aresetn  = 1'b0;
    logic        enable   = 1'b0;
    logic [3:0]  dec_log2 = 4'd0;
    logic [15:0] block_count;

    axis_ad7763_decimator_if s_if ();
    axis_ad7763_decimator_if m_if ();

    axis_ad7763_decimator dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .enable      (enable),
        .dec_log2    (dec_log2),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .block_count (block_count)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          exp_bc  = 0;
    int          rdy_mode = 1;     // 0: hold low, 1: hold high, 2: random
    logic [23:0] got_q[$];

    always #5 aclk = ~aclk;

    // Sink ready generator, updated just after each rising edge.
    always begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: record every accepted output beat.
    always @(negedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) got_q.push_back(m_if.tdata);
    end

    function automatic longint sx(input logic [23:0] d);
        return longint'($signed(d));
    endfunction

    // Reference: rounded average of a block sum at exponent k.
    function automatic logic [23:0] ref_avg(input longint sum, input int k);
        longint r;
        r = sum;
        if (k > 0) r = r + (longint'(1) << (k - 1));
        r = r >>> k;
        return r[23:0];
    endfunction

    function automatic int eff_k(input int k);
        return (k > 8) ? 8 : k;
    endfunction

    // Offer one sample (caller sits just after a rising edge); returns after acceptance.
    task automatic send(input logic [23:0] d, input int gap);
        int n;
        n = 0;
        s_if.tvalid = 1'b0;
        repeat (gap) begin @(posedge aclk); #1; end
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        @(negedge aclk);
        while (!s_if.tready && n < 2000) begin @(negedge aclk); n++; end
        if (n >= 2000) begin
            errors++;
            $display("FAIL send_timeout got tready=0 want 1 within 2000 cycles");
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    // Wait for n monitored outputs (bounded), then re-align to just after a rising edge.
    task automatic drain(input int n, output bit ok);
        int c;
        c = 0;
        while (got_q.size() < n && c < 8000) begin @(negedge aclk); c++; end
        repeat (3) @(negedge aclk);
        ok = (got_q.size() == n);
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b1; s_if.tvalid = 1'b0; s_if.tdata = '0;
        repeat (3) @(negedge aclk);
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b want 0", s_if.tready); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (m_if.tdata !== 24'h0) begin errors++; $display("FAIL rst_m_tdata got %h want 000000", m_if.tdata); end
        checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL rst_block_count got %0d want 0", block_count); end
        aresetn = 1'b1;
        #1;
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_release_tready got %b want 0", s_if.tready); end
        @(posedge aclk); #1;
        checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_first_clk_tready got %b want 1", s_if.tready); end
        exp_bc = 0;
    endtask

    task automatic test_k0_passthrough();
        logic [23:0] vals[3];
        bit ok;
        vals[0] = 24'h000001; vals[1] = 24'h7FFFFF; vals[2] = 24'h800000;
        dec_log2 = 4'd0; rdy_mode = 1; got_q.delete();
        @(posedge aclk); #1;
        for (int i = 0; i < 3; i++) begin
            send(vals[i], 0);
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== vals[i])
                begin errors++; $display("FAIL k0_latency[%0d] got v=%b d=%h want v=1 d=%h", i, m_if.tvalid, m_if.tdata, vals[i]); end
        end
        exp_bc += 3;
        checks++; if (block_count !== 16'(exp_bc)) begin errors++; $display("FAIL k0_block_count got %0d want %0d", block_count, exp_bc); end
        drain(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k0_out_count got %0d want 3", got_q.size()); end
    endtask

    task automatic test_k2_directed();
        logic [23:0] ins[8];
        logic [23:0] exp[2];
        bit ok;
        ins = '{24'd1, 24'd2, 24'd3, 24'd4, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE};
        exp[0] = 24'h000003; exp[1] = 24'hFFFFFF;
        dec_log2 = 4'd2; rdy_mode = 1; got_q.delete();
        for (int i = 0; i < 8; i++) send(ins[i], $urandom_range(0, 2));
        exp_bc += 2;
        drain(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k2_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL k2_avg[%0d] got %h want %h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_k8_extremes();
        bit ok;
        dec_log2 = 4'd8; rdy_mode = 1; got_q.delete();
        for (int i = 0; i < 256; i++) send(24'h7FFFFF, 0);
        for (int i = 0; i < 256; i++) send(24'h800000, 0);
        exp_bc += 2;
        drain(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k8_count got %0d want 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0] !== 24'h7FFFFF) begin errors++; $display("FAIL k8_max got %h want 7fffff", got_q[0]); end
            checks++; if (got_q[1] !== 24'h800000) begin errors++; $display("FAIL k8_min got %h want 800000", got_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        dec_log2 = 4'd1; rdy_mode = 0; got_q.delete();
        @(posedge aclk); #1;
        send(24'd4, 0);
        send(24'd6, 0);
        send(24'd3, 0);
        s_if.tdata = 24'd9; s_if.tvalid = 1'b1;
        repeat (5) @(negedge aclk);
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL bp_stall got tready=%b want 0", s_if.tready); end
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'd5)
            begin errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=000005", m_if.tvalid, m_if.tdata); end
        rdy_mode = 1;
        @(posedge aclk); #1;
        send(24'd9, 0);
        exp_bc += 2;
        drain(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_count got %0d want 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0] !== 24'd5) begin errors++; $display("FAIL bp_first got %h want 000005", got_q[0]); end
            checks++; if (got_q[1] !== 24'd6) begin errors++; $display("FAIL bp_second got %h want 000006", got_q[1]); end
        end
    endtask

    task automatic test_dec_change();
        logic [23:0] v[5];
        logic [23:0] exp[$];
        longint      sum;
        bit          ok;
        rdy_mode = 1; got_q.delete(); sum = 0;
        for (int i = 0; i < 5; i++) v[i] = 24'($urandom);
        dec_log2 = 4'd2;
        send(v[0], 0); send(v[1], 1);
        dec_log2 = 4'd0;
        send(v[2], 0); send(v[3], 2);
        for (int i = 0; i < 4; i++) sum += sx(v[i]);
        exp.push_back(ref_avg(sum, 2));
        send(v[4], 0);
        exp.push_back(v[4]);
        dec_log2 = 4'd15; sum = 0;
        for (int i = 0; i < 256; i++) begin
            logic [23:0] d;
            d = 24'($urandom);
            sum += sx(d);
            send(d, 0);
        end
        exp.push_back(ref_avg(sum, 8));
        exp_bc += 3;
        drain(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL decchg_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL decchg[%0d] got %h want %h", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_enable();
        bit ok;
        dec_log2 = 4'd2; rdy_mode = 1; got_q.delete();
        send(24'h123456, 0); send(24'h000100, 0); send(24'hF00000, 0);
        enable = 1'b0;
        send(24'h7FFFFF, 0);
        enable = 1'b1;
        checks++; if (block_count !== 16'(exp_bc)) begin errors++; $display("FAIL en_no_count got %0d want %0d", block_count, exp_bc); end
        for (int i = 0; i < 4; i++) send(24'd8, 0);
        exp_bc += 1;
        drain(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== 24'd8) begin errors++; $display("FAIL en_fresh_block got %h want 000008", got_q[0]); end
        end
        checks++; if (block_count !== 16'(exp_bc)) begin errors++; $display("FAIL en_block_count got %0d want %0d", block_count, exp_bc); end
    endtask

    task automatic test_random();
        logic [23:0] exp[$];
        bit          ok;
        rdy_mode = 2; got_q.delete();
        for (int b = 0; b < 12; b++) begin
            int     k;
            int     n;
            longint sum;
            k = $urandom_range(0, 15);
            n = 1 << eff_k(k);
            sum = 0;
            dec_log2 = 4'(k);
            for (int i = 0; i < n; i++) begin
                logic [23:0] d;
                d = 24'($urandom);
                sum += sx(d);
                send(d, $urandom_range(0, 2));
                if (i == 0) dec_log2 = 4'($urandom);
            end
            exp.push_back(ref_avg(sum, eff_k(k)));
        end
        exp_bc += 12;
        drain(12, ok);
        rdy_mode = 1;
        checks++; if (!ok) begin errors++; $display("FAIL rnd_count got %0d want 12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL rnd[%0d] got %h want %h", i, got_q[i], exp[i]); end
        end
        checks++; if (block_count !== 16'(exp_bc)) begin errors++; $display("FAIL rnd_block_count got %0d want %0d", block_count, exp_bc); end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        dec_log2 = 4'd0; rdy_mode = 0; got_q.delete();
        @(posedge aclk); #1;
        send(24'h0000AA, 0);
        dec_log2 = 4'd2;
        send(24'h000011, 0);
        @(negedge aclk); #2;
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", m_if.tvalid); end
        aresetn = 1'b0;
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (block_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", block_count); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready got %b want 0", s_if.tready); end
        exp_bc = 0;
        @(negedge aclk);
        aresetn = 1'b1; rdy_mode = 1;
        @(posedge aclk); #1;
        got_q.delete();
        dec_log2 = 4'd1;
        send(24'd10, 0); send(24'd13, 0);
        exp_bc += 1;
        drain(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_after_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== 24'd12) begin errors++; $display("FAIL mid_after_avg got %h want 00000c", got_q[0]); end
        end
        checks++; if (block_count !== 16'(exp_bc)) begin errors++; $display("FAIL mid_after_bc got %0d want %0d", block_count, exp_bc); end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        test_reset();
        test_k0_passthrough();
        test_k2_directed();
        test_k8_extremes();
        test_backpressure();
        test_dec_change();
        test_enable();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
